// File: rtl/mem_apb_bram_ws.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mem_apb_bram_ws                                            |
// | Description : APB slave memory on an inferred block RAM with configurable|
// |               read latency, write wait states and byte-lane writes.      |
// |               Optional macro MEM_APB_SLVERR_EN: out-of-range addresses   |
// |               complete with PSLVERR instead of wrapping.                 |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module mem_apb_bram_ws #(
  parameter int SIZE_IN_BYTES = 1024,
  parameter int RD_LATENCY    = 1,
  parameter int WR_WAIT       = 0
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic [31:0] PADDR,
  input  logic        PWRITE,
  input  logic [31:0] PWDATA,
  input  logic [3:0]  PSTRB,
  input  logic [2:0]  PPROT,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR
);

  localparam int c_DEPTH = SIZE_IN_BYTES / 4;
  localparam int c_AW    = $clog2(c_DEPTH);
  localparam int c_CNT_W = 2;

  // Wait-counter preload values: a read needs RD_LATENCY-1 stalls for the
  // pipeline to fill, a write simply stalls WR_WAIT cycles.
  localparam logic [c_CNT_W-1:0] c_WR_LOAD = c_CNT_W'(WR_WAIT);
  localparam logic [c_CNT_W-1:0] c_RD_LOAD = c_CNT_W'(RD_LATENCY - 1);

  localparam logic [0:0] c_ST_IDLE   = 1'b0;
  localparam logic [0:0] c_ST_ACCESS = 1'b1;

  logic [0:0]         r_state;
  logic [0:0]         w_next_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic [31:0]        r_mem     [c_DEPTH];
  logic [31:0]        r_rd_pipe [RD_LATENCY];

  logic [c_AW-1:0]    w_word;
  logic               w_setup;
  logic               w_access;
  logic               w_cnt_zero;
  logic               w_err;
  logic               w_wr_commit;
  logic               w_rd_done;
  logic               w_unused;

  assign w_word     = PADDR[c_AW+1:2];
  assign w_setup    = PSEL & ~PENABLE;
  assign w_access   = (r_state == c_ST_ACCESS);
  assign w_cnt_zero = (r_cnt == '0);

`ifdef MEM_APB_SLVERR_EN
  assign w_err = |PADDR[31:c_AW+2];
`else
  assign w_err = 1'b0;
`endif

  // Protection bits and the byte offset carry no meaning for this memory.
  assign w_unused = ^{PPROT, PADDR[31:c_AW+2], PADDR[1:0]};

  // Commit only from ACCESS so a stray enable during reset/idle cannot write.
  assign w_wr_commit = w_access & PSEL & PENABLE & PREADY & PWRITE & ~w_err;
  assign w_rd_done   = w_access & PREADY & ~PWRITE & ~w_err;

  // State register
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: leave ACCESS on completion or master abort
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_ST_IDLE:   if (w_setup) w_next_state = c_ST_ACCESS;
      c_ST_ACCESS: if (!PSEL || w_cnt_zero) w_next_state = c_ST_IDLE;
      default:     w_next_state = c_ST_IDLE;
    endcase
  end

  // Output logic: ready/error/data are all decoded from state and counter
  always_comb begin
    PREADY  = 1'b1;
    PSLVERR = 1'b0;
    PRDATA  = 32'h0;
    if (w_access) begin
      PREADY  = w_cnt_zero;
      PSLVERR = w_cnt_zero & w_err;
    end
    if (w_rd_done) begin
      PRDATA = r_rd_pipe[RD_LATENCY-1];
    end
  end

  // Wait-state counter: loaded in setup, counts down in ACCESS, cleared on abort
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_cnt <= '0;
    end else if (!w_access) begin
      if (w_setup && !w_err) begin
        r_cnt <= PWRITE ? c_WR_LOAD : c_RD_LOAD;
      end else begin
        r_cnt <= '0;
      end
    end else if (!PSEL) begin
      r_cnt <= '0;
    end else if (!w_cnt_zero) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // Byte-lane write port; contents are deliberately not reset
  always_ff @(posedge PCLK) begin
    if (w_wr_commit) begin
      for (int b = 0; b < 4; b++) begin
        if (PSTRB[b]) begin
          r_mem[w_word][8*b +: 8] <= PWDATA[8*b +: 8];
        end
      end
    end
  end

  // Read port plus optional output registers; the address is sampled every
  // cycle, which is safe because APB holds PADDR stable for the transfer
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int k = 0; k < RD_LATENCY; k++) begin
        r_rd_pipe[k] <= 32'h0;
      end
    end else begin
      r_rd_pipe[0] <= r_mem[w_word];
      for (int k = 1; k < RD_LATENCY; k++) begin
        r_rd_pipe[k] <= r_rd_pipe[k-1];
      end
    end
  end

endmodule
`default_nettype wire
